uart_tx_arb: RTL and testbench
==============================

UART_TX_ARB -- requirements
Module: uart_tx_arb

Interface
REQ-001 SHALL have parameter NREQ, default 4, number of byte requesters (2..8).
REQ-002 SHALL have parameter TIMEOUT_CYC, default 1024, watchdog limit in clk cycles (used only with UART_ARB_TIMEOUT_EN).
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port clr_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port req  input  NREQ  per-requester send request, held until matching gnt.
REQ-006 SHALL have port req_data  input  NREQ x 8  per-requester byte, stable while req high.
REQ-007 SHALL have port gnt  output  NREQ  one-hot one-cycle acceptance pulse.
REQ-008 SHALL have port ready  output  1  start pulse to the UART transmitter.
REQ-009 SHALL have port tx_data  output  8  byte to the UART transmitter.
REQ-010 SHALL have port tdre  input  1  transmitter empty: 1 = idle, 0 = shifting.
REQ-011 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-012 SHALL have port err  output  1  one-cycle timeout pulse (tied 0 without UART_ARB_TIMEOUT_EN).

Function
REQ-013 SHALL implement FSM states IDLE, LOAD, WAIT_BUSY, WAIT_DONE.
REQ-014 IDLE: if any req=1 and tdre=1, SHALL select winner round-robin, register req_data[winner] into tx_data, go to LOAD; otherwise stay.
REQ-015 Round-robin search SHALL start at index last_winner+1, wrap from NREQ-1 to 0; last_winner = NREQ-1 after reset, so index 0 wins first.
REQ-016 LOAD: ready=1 and gnt[winner]=1 for exactly one cycle, then WAIT_BUSY; req-to-gnt latency = 2 cycles from req sampled in IDLE.
REQ-017 WAIT_BUSY: SHALL wait for tdre=0, then go to WAIT_DONE.
REQ-018 WAIT_DONE: SHALL wait for tdre=1, then go to IDLE; next grant no earlier than 1 cycle after return to IDLE.
REQ-019 tdre=1 in IDLE with no req SHALL leave all outputs at reset values except tx_data, which holds the last byte.
REQ-020 A req dropped after capture (before gnt) SHALL NOT cancel the transfer; the byte is sent and gnt still pulses.
REQ-021 A requester holding req after its gnt SHALL be treated as a new request; it loses to any other pending requester.
REQ-022 tdre=0 in IDLE (external transmitter busy) SHALL block grants until tdre=1.
REQ-023 ready, gnt, busy, err SHALL be registered outputs; gnt SHALL never have more than one bit set.

Reset
REQ-024 clr_n=0 SHALL asynchronously force state=IDLE, ready=0, gnt=0, tx_data=8'h00, busy=0, err=0, last_winner=NREQ-1.
REQ-025 Reset mid-transfer SHALL abandon the byte with no gnt; after release the arbiter waits in IDLE for tdre=1.

Configuration
REQ-026 Macro UART_ARB_TIMEOUT_EN defined: counter SHALL run in WAIT_BUSY and WAIT_DONE, and at TIMEOUT_CYC cycles in either state SHALL pulse err, go to IDLE, and keep last_winner updated.
REQ-027 Macro UART_ARB_TIMEOUT_EN undefined: no counter, err tied 0, WAIT states wait indefinitely.

Structure
REQ-028 Package uart_arb_pkg SHALL hold the state enum type, NREQ_MAX=8 and default TIMEOUT_CYC.
REQ-029 Round-robin selection SHALL be sub-module uart_rr_pick (inputs req, last_winner; outputs valid, winner index), combinational.

Verification
REQ-030 Single req[0] with 8'hA5, tdre model 10-cycle busy -> gnt[0] pulse 2 cycles after req, ready pulse coincident, tx_data=8'hA5.
REQ-031 req=4'b1111 held continuously -> grant order 0,1,2,3,0; each byte on tx_data matches its requester.
REQ-032 req[3] only, then req[0] and req[3] together -> 0 wins, then 3 (wrap-around check).
REQ-033 tdre forced 0 in IDLE with req[1]=1 -> no gnt and no ready until tdre=1, then grant within 2 cycles.
REQ-034 clr_n pulsed low during WAIT_DONE -> immediate IDLE, all outputs at reset values, no gnt; next req[0] granted first.
REQ-035 With UART_ARB_TIMEOUT_EN, TIMEOUT_CYC=16, tdre stuck 1 after ready -> err pulse at cycle 16 of WAIT_BUSY, return to IDLE.

Source files
------------

// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART transmit arbiter.
package uart_arb_pkg;

  localparam int unsigned NREQ_MAX        = 8;
  localparam int unsigned TIMEOUT_CYC_DEF = 1024;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD      = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } arb_state_e;

  // Width of a requester index (never below one bit).
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker: first set req after last_winner, wrapping.
module uart_rr_pick
  import uart_arb_pkg::*;
#(
  parameter int unsigned NREQ = 4
) (
  input  logic [NREQ-1:0]          req,
  input  logic [idx_w(NREQ)-1:0]   last_winner,
  output logic                     valid,
  output logic [idx_w(NREQ)-1:0]   winner
);

  localparam int unsigned IW = idx_w(NREQ);

  logic [31:0] cand;

  // Scan NREQ slots starting one past the previous winner; first hit wins.
  always_comb begin
    valid  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int unsigned i = 1; i <= NREQ; i++) begin
      cand = 32'(last_winner) + 32'(i);
      if (cand >= 32'(NREQ)) cand = cand - 32'(NREQ);
      if (!valid && req[cand[IW-1:0]]) begin
        valid  = 1'b1;
        winner = cand[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter feeding bytes from NREQ requesters into one UART transmitter.
// Optional watchdog on the WAIT states: define UART_ARB_TIMEOUT_EN.
module uart_tx_arb
  import uart_arb_pkg::*;
#(
  parameter int unsigned NREQ        = 4,
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic                  clk,
  input  logic                  clr_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ-1:0][7:0]  req_data,
  output logic [NREQ-1:0]       gnt,
  output logic                  ready,
  output logic [7:0]            tx_data,
  input  logic                  tdre,
  output logic                  busy,
  output logic                  err
);

  localparam int unsigned IW = idx_w(NREQ);

  arb_state_e       state;
  logic [IW-1:0]    last_winner;
  logic [IW-1:0]    win_q;
  logic             pick_valid;
  logic [IW-1:0]    pick_idx;
  logic             tmo_hit_c;

  uart_rr_pick #(.NREQ(NREQ)) u_pick (
    .req         (req),
    .last_winner (last_winner),
    .valid       (pick_valid),
    .winner      (pick_idx)
  );

`ifdef UART_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

  logic [CNT_W-1:0] tmo_cnt;
  logic             waiting_c;

  // Still waiting on the transmitter in either WAIT state.
  assign waiting_c = ((state == WAIT_BUSY) &&  tdre) ||
                     ((state == WAIT_DONE) && !tdre);
  assign tmo_hit_c = waiting_c && (tmo_cnt == CNT_W'(TIMEOUT_CYC - 1));

  // Watchdog: counts consecutive waiting cycles, restarts on any state change.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      tmo_cnt <= '0;
      err     <= 1'b0;
    end else begin
      err     <= tmo_hit_c;
      tmo_cnt <= (waiting_c && !tmo_hit_c) ? tmo_cnt + CNT_W'(1) : '0;
    end
  end
`else
  logic unused_cfg;

  assign tmo_hit_c  = 1'b0;
  assign err        = 1'b0;
  assign unused_cfg = |TIMEOUT_CYC;
`endif

  // Arbiter FSM with registered handshake outputs.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state       <= IDLE;
      ready       <= 1'b0;
      gnt         <= '0;
      tx_data     <= 8'h00;
      busy        <= 1'b0;
      last_winner <= IW'(NREQ - 1);
      win_q       <= '0;
    end else begin
      ready <= 1'b0;
      gnt   <= '0;
      case (state)
        IDLE: begin
          if (pick_valid && tdre) begin
            tx_data     <= req_data[pick_idx];
            win_q       <= pick_idx;
            last_winner <= pick_idx;
            state       <= LOAD;
            busy        <= 1'b1;
          end else begin
            busy <= 1'b0;
          end
        end
        LOAD: begin
          ready <= 1'b1;
          gnt   <= NREQ'(1) << win_q;
          state <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (!tdre) begin
            state <= WAIT_DONE;
          end else if (tmo_hit_c) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        WAIT_DONE: begin
          if (tdre || tmo_hit_c) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arb.sv
// Directed bench for uart_tx_arb with a grant scoreboard and a simple transmitter model.
module tb_uart_tx_arb;

  localparam int unsigned NREQ = 4;

  typedef struct packed {
    logic [2:0] idx;
    logic [7:0] data;
  } exp_t;

  logic                 clk;
  logic                 clr_n;
  logic [NREQ-1:0]      req;
  logic [NREQ-1:0][7:0] req_data;
  logic [NREQ-1:0]      gnt;
  logic                 ready;
  logic [7:0]           tx_data;
  logic                 tdre;
  logic                 busy;
  logic                 err;

  logic                 tdre_m;
  logic                 force_low;
  logic                 stuck;
  logic [NREQ-1:0]      hold;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   gcount   = 0;

  uart_tx_arb #(.NREQ(NREQ), .TIMEOUT_CYC(16)) dut (
    .clk      (clk),
    .clr_n    (clr_n),
    .req      (req),
    .req_data (req_data),
    .gnt      (gnt),
    .ready    (ready),
    .tx_data  (tx_data),
    .tdre     (tdre),
    .busy     (busy),
    .err      (err)
  );

  assign tdre = tdre_m & ~force_low;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic expect_gnt(input int idx, input logic [7:0] d);
    exp_t e;
    e.idx  = 3'(idx);
    e.data = d;
    exp_q.push_back(e);
  endtask

  // Advance one cycle; requesters not holding drop req on their grant.
  task automatic cyc();
    @(negedge clk);
    if (gnt != '0) gcount++;
    req = req & ~(gnt & ~hold);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || busy || !tdre) && n < 300) begin
      cyc();
      n++;
    end
    check(name, 32'(n < 300), 32'd1);
  endtask

  task automatic wait_grants(input int k, input string name);
    int base = gcount;
    int n = 0;
    while ((gcount - base) < k && n < 300) begin
      cyc();
      n++;
    end
    check(name, 32'(n < 300), 32'd1);
  endtask

  task automatic do_reset();
    clr_n = 1'b0;
    cyc();
    cyc();
    clr_n = 1'b1;
    cyc();
  endtask

  // Transmitter model: goes busy for 10 cycles after each ready pulse.
  initial begin
    tdre_m = 1'b1;
    forever begin
      @(negedge clk);
      if (ready && !stuck) begin
        tdre_m = 1'b0;
        repeat (10) @(negedge clk);
        tdre_m = 1'b1;
      end
    end
  end

  // Scoreboard monitor: every grant must match the next expected requester/byte.
  always @(negedge clk) begin
    if (clr_n && (gnt != '0 || ready)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_gnt", 32'(gnt), 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("gnt_idx",     32'(gnt),     32'd1 << e.idx);
        check("gnt_tx_data", 32'(tx_data), 32'(e.data));
        check("gnt_ready",   32'(ready),   32'd1);
        check("gnt_err",     32'(err),     32'd0);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    int   n;
    logic seen;
    clr_n     = 1'b0;
    req       = '0;
    req_data  = '0;
    hold      = '0;
    force_low = 1'b0;
    stuck     = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ready",   32'(ready),   32'd0);
    check("rst_gnt",     32'(gnt),     32'd0);
    check("rst_busy",    32'(busy),    32'd0);
    check("rst_err",     32'(err),     32'd0);
    check("rst_tx_data", 32'(tx_data), 32'h00);
    clr_n = 1'b1;
    cyc();

    // Single requester: grant two cycles after req is sampled.
    req_data[0] = 8'hA5;
    req[0]      = 1'b1;
    expect_gnt(0, 8'hA5);
    cyc();
    check("lat_1cyc_gnt", 32'(gnt), 32'd0);
    check("lat_1cyc_busy", 32'(busy), 32'd1);
    cyc();
    check("lat_2cyc_gnt",   32'(gnt),     32'd1);
    check("lat_2cyc_ready", 32'(ready),   32'd1);
    check("lat_2cyc_data",  32'(tx_data), 32'hA5);
    wait_idle("single_done");
    repeat (3) cyc();
    check("idle_tx_hold", 32'(tx_data), 32'hA5);
    check("idle_busy",    32'(busy),    32'd0);
    check("idle_gnt",     32'(gnt),     32'd0);
    check("idle_ready",   32'(ready),   32'd0);

    // All four held: 0,1,2,3,0 from a fresh reset.
    do_reset();
    for (int i = 0; i < 4; i++) req_data[i] = 8'h10 + 8'(i);
    expect_gnt(0, 8'h10);
    expect_gnt(1, 8'h11);
    expect_gnt(2, 8'h12);
    expect_gnt(3, 8'h13);
    expect_gnt(0, 8'h10);
    hold = 4'hF;
    req  = 4'hF;
    wait_grants(5, "rr_grants");
    req  = '0;
    hold = '0;
    wait_idle("rr_done");

    // Wrap-around: 3 alone, then 0 and 3 together -> 0 then 3.
    req_data[3] = 8'hC3;
    req[3]      = 1'b1;
    expect_gnt(3, 8'hC3);
    wait_idle("wrap_first");
    req_data[0] = 8'h0F;
    req[0]      = 1'b1;
    req[3]      = 1'b1;
    expect_gnt(0, 8'h0F);
    expect_gnt(3, 8'hC3);
    wait_idle("wrap_done");

    // Requester 1 keeps req after its grant and yields to requester 2.
    req_data[1] = 8'h21;
    req_data[2] = 8'h42;
    hold[1]     = 1'b1;
    req[1]      = 1'b1;
    req[2]      = 1'b1;
    expect_gnt(1, 8'h21);
    expect_gnt(2, 8'h42);
    expect_gnt(1, 8'h21);
    wait_grants(3, "held_grants");
    req[1] = 1'b0;
    hold   = '0;
    wait_idle("held_done");

    // req dropped after capture still completes with a grant.
    req_data[2] = 8'h5C;
    req[2]      = 1'b1;
    expect_gnt(2, 8'h5C);
    cyc();
    req[2] = 1'b0;
    wait_idle("drop_done");

    // Transmitter busy in IDLE blocks grants.
    force_low = 1'b1;
    cyc();
    req_data[1] = 8'h3C;
    req[1]      = 1'b1;
    expect_gnt(1, 8'h3C);
    for (int i = 0; i < 6; i++) begin
      cyc();
      check("blk_gnt",   32'(gnt),   32'd0);
      check("blk_ready", 32'(ready), 32'd0);
    end
    force_low = 1'b0;
    seen      = 1'b0;
    for (int i = 0; i < 2; i++) begin
      cyc();
      if (gnt[1]) seen = 1'b1;
    end
    check("unblock_gnt_2cyc", 32'(seen), 32'd1);
    wait_idle("unblock_done");

    // Reset during WAIT_DONE.
    req_data[2] = 8'h77;
    req[2]      = 1'b1;
    expect_gnt(2, 8'h77);
    n = 0;
    while (!(busy && !tdre) && n < 50) begin
      cyc();
      n++;
    end
    check("reach_wait_done", 32'(n < 50), 32'd1);
    repeat (3) cyc();
    #2 clr_n = 1'b0;
    #1;
    check("mid_rst_busy",    32'(busy),    32'd0);
    check("mid_rst_gnt",     32'(gnt),     32'd0);
    check("mid_rst_ready",   32'(ready),   32'd0);
    check("mid_rst_err",     32'(err),     32'd0);
    check("mid_rst_tx_data", 32'(tx_data), 32'h00);
    @(negedge clk);
    clr_n       = 1'b1;
    req_data[0] = 8'h01;
    req_data[1] = 8'h02;
    req[0]      = 1'b1;
    req[1]      = 1'b1;
    expect_gnt(0, 8'h01);
    expect_gnt(1, 8'h02);
    wait_idle("post_rst_done");

`ifdef UART_ARB_TIMEOUT_EN
    // Transmitter never goes busy: watchdog fires on the 16th WAIT_BUSY cycle.
    stuck       = 1'b1;
    req_data[3] = 8'hE1;
    req[3]      = 1'b1;
    expect_gnt(3, 8'hE1);
    n = 0;
    while (gnt == '0 && n < 10) begin
      cyc();
      n++;
    end
    check("to_gnt_seen", 32'(n < 10), 32'd1);
    repeat (15) cyc();
    check("to_err_early", 32'(err),  32'd0);
    check("to_busy_early", 32'(busy), 32'd1);
    cyc();
    check("to_err",  32'(err),  32'd1);
    check("to_busy", 32'(busy), 32'd0);
    cyc();
    check("to_err_pulse", 32'(err), 32'd0);
    stuck = 1'b0;
    wait_idle("to_done");
`endif

    check("final_err",  32'(err),          32'd0);
    check("sb_drain",   32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
